// File: rtl/pyonpyon_pkg.sv
// Shared constants, plotter state encoding and box request payload.
package pyonpyon_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } plot_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } box_req_t;

endpackage

// File: rtl/box_req_fifo.sv
// Synchronous request FIFO holding {x,y,colour} box requests.
module box_req_fifo
    import pyonpyon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  box_req_t               wdata,
    output box_req_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    box_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/box_plotter.sv
// Queued box-fill engine: rasterises box requests into a clipped pixel stream.
module box_plotter
    import pyonpyon_pkg::*;
#(
    parameter int unsigned BOX_W      = 4,
    parameter int unsigned BOX_H      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = 4;
    localparam int unsigned QW = $clog2(FIFO_DEPTH) + 1;

    plot_state_t   state;
    logic [7:0]    ox;
    logic [6:0]    oy;
    logic [2:0]    oc;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [8:0]    px;
    logic [7:0]    py;

    box_req_t      head;
    box_req_t      req_in;
    logic          fifo_full;
    logic          fifo_empty;
    logic [QW-1:0] fifo_count;
    logic          fifo_pop;

    assign req_in   = '{x: req_x, y: req_y, colour: req_colour};
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    box_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .pop   (fifo_pop),
        .wdata (req_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Control FSM: load a queued box, walk dx fastest then dy, then pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ox    <= '0;
            oy    <= '0;
            oc    <= '0;
            dx    <= '0;
            dy    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        ox    <= head.x;
                        oy    <= head.y;
                        oc    <= head.colour;
                        dx    <= '0;
                        dy    <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (dx == CW'(BOX_W - 1)) begin
                        dx <= '0;
                        if (dy == CW'(BOX_H - 1)) begin
                            state <= DONE;
                        end else begin
                            dy <= dy + CW'(1);
                        end
                    end else begin
                        dx <= dx + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Widened pixel address so off-screen pixels are clipped instead of wrapping.
    assign px = 9'(ox) + 9'(dx);
    assign py = 8'(oy) + 8'(dy);

    // Output decode from registered state and counters only.
    always_comb begin
        x      = '0;
        y      = '0;
        colour = BLACK;
        plot   = 1'b0;
        if (state == DRAW) begin
            x      = px[7:0];
            y      = py[6:0];
            colour = oc;
            plot   = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
        end
    end

    assign done      = (state == DONE);
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign req_ready = !fifo_full;

endmodule

// File: tb/tb_box_plotter.sv
// Self-checking bench for box_plotter: directed tables plus randomized model compare.
module tb_box_plotter;
    import pyonpyon_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    logic       req_valid1, req_ready1;
    logic [7:0] req_x1, x1;
    logic [6:0] req_y1, y1;
    logic [2:0] req_colour1, colour1;
    logic       plot1, busy1, done1;

    int errors = 0;
    int checks = 0;

    box_plotter #(.BOX_W(W), .BOX_H(H), .FIFO_DEPTH(QD)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    box_plotter #(.BOX_W(1), .BOX_H(1), .FIFO_DEPTH(QD)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_x(req_x1), .req_y(req_y1), .req_colour(req_colour1),
        .x(x1), .y(y1), .colour(colour1), .plot(plot1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted boxes and a phase index into the current box.
    // k = -1 idle, 0..N-1 drawing pixel k, N = done cycle.
    box_req_t mq[$];
    box_req_t cur;
    int       k = -1;
    bit       last_push;
    int       done_seen = 0;
    int       plot_seen = 0;

    typedef struct {
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic       ep;
    } pix_t;
    pix_t tbl[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, push;
        last_push = 1'b0;
        if (reset) begin
            mq.delete();
            k = -1;
            return;
        end
        pop  = (k == -1) && (mq.size() > 0);
        push = req_valid && (mq.size() < QD);
        if (k == -1) begin
            if (pop) begin
                cur = mq.pop_front();
                k = 0;
            end
        end else if (k == N) begin
            k = -1;
        end else begin
            k++;
        end
        if (push) begin
            mq.push_back('{x: req_x, y: req_y, colour: req_colour});
            last_push = 1'b1;
        end
    endtask

    task automatic model_compare();
        int px, py;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic ep, eb, ed, er;
        ex = '0; ey = '0; ec = '0; ep = 1'b0;
        if (k >= 0 && k < N) begin
            px = int'(cur.x) + (k % W);
            py = int'(cur.y) + (k / W);
            ex = px[7:0];
            ey = py[6:0];
            ec = cur.colour;
            ep = (px < 160) && (py < 120);
        end
        ed = (k == N);
        eb = (k != -1) || (mq.size() > 0);
        er = (mq.size() < QD);
        check("model", 32'({x, y, colour, plot, busy, done, req_ready}),
              32'({ex, ey, ec, ep, eb, ed, er}));
    endtask

    // One clock: model advances with the DUT edge, outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (done) done_seen++;
        if (plot) plot_seen++;
        model_compare();
    endtask

    task automatic setpix(input int i, input int px, input int py, input int c, input bit p);
        tbl[i].ex = 8'(px);
        tbl[i].ey = 7'(py);
        tbl[i].ec = 3'(c);
        tbl[i].ep = p;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((k != -1 || mq.size() > 0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) check({name, "_timeout"}, 32'(n), 32'(0));
    endtask

    task automatic run_table_box(input logic [7:0] bx, input logic [6:0] by,
                                 input logic [2:0] bc, input int base);
        req_valid = 1'b1; req_x = bx; req_y = by; req_colour = bc;
        step();
        req_valid = 1'b0;
        check("tbl_idle_plot", 32'(plot), 32'(0));
        for (int i = 0; i < N; i++) begin
            step();
            check("tbl_pixel", 32'({x, y, colour, plot, done}),
                  32'({tbl[base+i].ex, tbl[base+i].ey, tbl[base+i].ec, tbl[base+i].ep, 1'b0}));
        end
        step();
        check("tbl_done", 32'({done, plot}), 32'({1'b1, 1'b0}));
        step();
        check("tbl_after", 32'({done, busy}), 32'(0));
    endtask

    initial begin
        int d0, p0, n;

        // Box at (38,3) colour 7, fully on screen.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                setpix(r*4 + c, 38 + c, 3 + r, 7, 1'b1);
        // Box at (158,118) colour 4, clipped right and bottom.
        setpix(12, 158, 118, 4, 1'b1);
        setpix(13, 159, 118, 4, 1'b1);
        setpix(14, 160, 118, 4, 1'b0);
        setpix(15, 161, 118, 4, 1'b0);
        setpix(16, 158, 119, 4, 1'b1);
        setpix(17, 159, 119, 4, 1'b1);
        setpix(18, 160, 119, 4, 1'b0);
        setpix(19, 161, 119, 4, 1'b0);
        setpix(20, 158, 120, 4, 1'b0);
        setpix(21, 159, 120, 4, 1'b0);
        setpix(22, 160, 120, 4, 1'b0);
        setpix(23, 161, 120, 4, 1'b0);

        reset = 1'b1;
        req_valid = 1'b0; req_x = '0; req_y = '0; req_colour = '0;
        req_valid1 = 1'b0; req_x1 = '0; req_y1 = '0; req_colour1 = '0;
        @(negedge clk);
        step();
        step();
        check("reset_outs", 32'({x, y, colour, plot, done, busy}), 32'(0));
        check("reset_ready", 32'(req_ready), 32'(1));
        reset = 1'b0;
        step();

        // Directed table-driven boxes.
        run_table_box(8'd38, 7'd3, WHITE, 0);
        run_table_box(8'd158, 7'd118, 3'b100, 12);

        // Hold valid for 7 cycles, then keep presenting one more until taken.
        d0 = done_seen; p0 = plot_seen;
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_x = 8'(10 + i*20); req_y = 7'd10; req_colour = 3'(i);
            check("hold_ready", 32'(req_ready), 32'(i < 5));
            step();
        end
        req_x = 8'd150; req_y = 7'd100; req_colour = 3'd5;
        n = 0;
        do begin
            if (k == -1 && mq.size() == QD) check("full_pop_ready", 32'(req_ready), 32'(0));
            step();
            n++;
        end while (!last_push && n < 100);
        if (n >= 100) check("full_accept_timeout", 32'(n), 32'(0));
        req_valid = 1'b0;
        drain("hold");
        check("hold_done_count", 32'(done_seen - d0), 32'(6));
        check("hold_plot_count", 32'(plot_seen - p0), 32'(6 * N));

        // Reset on the 5th pixel of a box with two queued behind it.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_x = 8'(20 + i*10); req_y = 7'(30 + i); req_colour = 3'(i + 1);
            step();
        end
        req_valid = 1'b0;
        n = 0;
        while (k != 4 && n < 50) begin step(); n++; end
        check("rst_queued", 32'(mq.size()), 32'(2));
        check("rst_fifth_plot", 32'({plot, x}), 32'({1'b1, 8'd20}));
        reset = 1'b1;
        p0 = plot_seen; d0 = done_seen;
        step();
        reset = 1'b0;
        check("rst_state", 32'({plot, done, busy, req_ready}), 32'({1'b0, 1'b0, 1'b0, 1'b1}));
        for (int i = 0; i < 30; i++) step();
        check("rst_no_pixels", 32'(plot_seen - p0), 32'(0));
        check("rst_no_done", 32'(done_seen - d0), 32'(0));

        // 1x1 build: single pixel at (0,0) followed by done.
        req_valid1 = 1'b1; req_x1 = 8'd0; req_y1 = 7'd0; req_colour1 = WHITE;
        step();
        req_valid1 = 1'b0;
        check("one_idle", 32'({plot1, busy1, done1}), 32'({1'b0, 1'b1, 1'b0}));
        step();
        check("one_pixel", 32'({x1, y1, colour1, plot1, done1}),
              32'({8'd0, 7'd0, 3'd7, 1'b1, 1'b0}));
        step();
        check("one_done", 32'({plot1, done1}), 32'({1'b0, 1'b1}));
        step();
        check("one_after", 32'({plot1, done1, busy1, req_ready1}), 32'({3'b000, 1'b1}));

        // Randomized traffic, biased towards the clipping edges.
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: begin req_x = 8'($urandom_range(150, 255)); req_y = 7'($urandom_range(110, 127)); end
                1: begin req_x = 8'($urandom_range(0, 159));   req_y = 7'($urandom_range(0, 119)); end
                default: begin req_x = 8'($urandom); req_y = 7'($urandom); end
            endcase
            req_colour = 3'($urandom);
            step();
        end
        req_valid = 1'b0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
